// File: rtl/gcn_pkg.sv
// ============================================================================
// Module      : gcn_pkg
// Description : Shared constants, FSM state type and the output
//               saturate/shift helper for the GCN aggregation datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gcn_pkg;

  localparam int N_NODE = 25;   // nodes per vector, also columns per accumulation
  localparam int DW     = 16;   // signed Q8.8 element width
  localparam int ACC_W  = 40;   // per-node accumulator width
  localparam int FRAC   = 8;    // fractional bits dropped on output
  localparam int IDX_W  = 5;    // result index width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Arithmetic shift right by FRAC, then clamp to the signed DW range.
  // The value fits when every bit from the DW-1 position upward matches the sign.
  function automatic logic signed [DW-1:0] sat_shift(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    logic [ACC_W-DW:0]       top;
    sh  = acc >>> FRAC;
    top = sh[ACC_W-1:DW-1];
    if ((top == '0) || (top == '1))
      sat_shift = sh[DW-1:0];
    else if (sh[ACC_W-1])
      sat_shift = {1'b1, {(DW-1){1'b0}}};
    else
      sat_shift = {1'b0, {(DW-1){1'b1}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/gcn_mac_lane.sv
// ============================================================================
// Module      : gcn_mac_lane
// Description : One node lane: registered DW x DW signed product (stage 1)
//               followed by a sign-extending accumulator with clear (stage 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcn_mac_lane
  import gcn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic signed [DW-1:0]    i_a,
  input  logic signed [DW-1:0]    i_x,
  input  logic                    i_add,
  input  logic                    i_clr,
  output logic signed [ACC_W-1:0] o_acc
);

  localparam int PW = 2 * DW;

  logic signed [PW-1:0]    r_prod;
  logic signed [PW-1:0]    w_prod;
  logic signed [ACC_W-1:0] r_acc;

  // Operands are widened first so the full signed product is kept.
  assign w_prod = PW'(i_a) * PW'(i_x);

  // Stage 1: capture the product of the accepted beat.
  always_ff @(posedge clk) begin
    if (!rst)
      r_prod <= '0;
    else if (i_load)
      r_prod <= w_prod;
  end

  // Stage 2: accumulate the sign-extended product; clear once drained.
  always_ff @(posedge clk) begin
    if (!rst)
      r_acc <= '0;
    else if (i_clr)
      r_acc <= '0;
    else if (i_add)
      r_acc <= r_acc + ACC_W'(r_prod);
  end

  assign o_acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/gcn_agg_acc.sv
// ============================================================================
// Module      : gcn_agg_acc
// Description : Accumulates y = A*x column by column (one A column plus one
//               feature scalar per beat), then drains N_NODE saturated results
//               serially while holding the upstream A-matrix controller halted.
//               Build option GCN_AGG_RELU_EN: negative results are output as 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcn_agg_acc
  import gcn_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mx_v,
  input  logic [N_NODE*DW-1:0]   mx_col,
  input  logic                   ft_v,
  input  logic [DW-1:0]          ft_data,
  output logic                   halt_out,
  output logic                   res_v,
  output logic [DW-1:0]          res_data,
  output logic [IDX_W-1:0]       res_idx,
  input  logic                   res_rdy,
  output logic                   done,
  output logic                   err_sync
);

  state_t                  r_state;
  state_t                  w_next;
  logic [IDX_W-1:0]        r_col_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_p_v;
  logic                    r_done;
  logic                    r_err;

  logic                    w_halt;
  logic                    w_res_v;
  logic                    w_accept;
  logic                    w_misalign;
  logic                    w_fire;
  logic                    w_last_col;
  logic                    w_last_res;
  logic signed [ACC_W-1:0] w_acc [N_NODE];
  logic signed [DW-1:0]    w_sat;
  logic signed [DW-1:0]    w_res;

  // Beats are only looked at while the upstream is not halted.
  assign w_accept   = mx_v && ft_v && !w_halt;
  assign w_misalign = (mx_v ^ ft_v) && !w_halt;
  assign w_fire     = w_res_v && res_rdy;
  assign w_last_col = (r_col_cnt == IDX_W'(N_NODE - 1));
  assign w_last_res = (r_idx == IDX_W'(N_NODE - 1));

  generate
    for (genvar gi = 0; gi < N_NODE; gi++) begin : g_lane
      gcn_mac_lane u_lane (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept),
        .i_a    (mx_col[gi*DW +: DW]),
        .i_x    (ft_data),
        .i_add  (r_p_v),
        .i_clr  (w_fire && (r_idx == IDX_W'(gi))),
        .o_acc  (w_acc[gi])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // Next-state logic; FLUSH waits only on stage 1 since stage 2 lands on the same edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = ACC;
      ACC:     if (w_accept && w_last_col) w_next = FLUSH;
      FLUSH:   if (!r_p_v) w_next = DRAIN;
      DRAIN:   if (w_fire && w_last_res) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    w_halt  = 1'b0;
    w_res_v = 1'b0;
    case (r_state)
      FLUSH: w_halt = 1'b1;
      DRAIN: begin
        w_halt  = 1'b1;
        w_res_v = 1'b1;
      end
      default: begin
        w_halt  = 1'b0;
        w_res_v = 1'b0;
      end
    endcase
  end

  // Column counter: counts accepted beats, rewinds when the drain completes.
  always_ff @(posedge clk) begin
    if (!rst)
      r_col_cnt <= '0;
    else if (w_fire && w_last_res)
      r_col_cnt <= '0;
    else if (w_accept)
      r_col_cnt <= r_col_cnt + IDX_W'(1);
  end

  // Stage-1 valid tracks the accepted beat into the accumulate stage.
  always_ff @(posedge clk) begin
    if (!rst)
      r_p_v <= 1'b0;
    else
      r_p_v <= w_accept;
  end

  // Result index advances on each handshake, wraps after the last node.
  always_ff @(posedge clk) begin
    if (!rst)
      r_idx <= '0;
    else if (w_fire)
      r_idx <= w_last_res ? '0 : r_idx + IDX_W'(1);
  end

  // Done pulses for one cycle after the last result is taken.
  always_ff @(posedge clk) begin
    if (!rst)
      r_done <= 1'b0;
    else
      r_done <= w_fire && w_last_res;
  end

  // Sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (!rst)
      r_err <= 1'b0;
    else if (w_misalign)
      r_err <= 1'b1;
  end

  assign w_sat = sat_shift(w_acc[r_idx]);

  // Optional fused ReLU on the saturated result.
  always_comb begin
`ifdef GCN_AGG_RELU_EN
    w_res = w_sat[DW-1] ? '0 : w_sat;
`else
    w_res = w_sat;
`endif
  end

  assign halt_out = w_halt;
  assign res_v    = w_res_v;
  assign res_data = w_res_v ? w_res : '0;
  assign res_idx  = r_idx;
  assign done     = r_done;
  assign err_sync = r_err;

endmodule

`default_nettype wire

// File: tb/tb_gcn_agg_acc.sv
// ============================================================================
// Module      : tb_gcn_agg_acc
// Description : Scoreboard bench for gcn_agg_acc with directed column vectors.
//               Expected results are queued when a vector is issued; a monitor
//               pops and compares on every result handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gcn_agg_acc;
  import gcn_pkg::*;

  localparam int CW = N_NODE * DW;

`ifdef GCN_AGG_RELU_EN
  localparam logic [DW-1:0] NEG_EXP = 16'h0000;
`else
  localparam logic [DW-1:0] NEG_EXP = 16'h8000;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             mx_v;
  logic [CW-1:0]    mx_col;
  logic             ft_v;
  logic [DW-1:0]    ft_data;
  logic             halt_out;
  logic             res_v;
  logic [DW-1:0]    res_data;
  logic [IDX_W-1:0] res_idx;
  logic             res_rdy;
  logic             done;
  logic             err_sync;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [DW-1:0]    data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   t_last  = 0;

  logic             prev_v   = 1'b0;
  logic             prev_rdy = 1'b0;
  logic [DW-1:0]    prev_data = '0;
  logic [IDX_W-1:0] prev_idx  = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gcn_agg_acc dut (
    .clk      (clk),
    .rst      (rst),
    .mx_v     (mx_v),
    .mx_col   (mx_col),
    .ft_v     (ft_v),
    .ft_data  (ft_data),
    .halt_out (halt_out),
    .res_v    (res_v),
    .res_data (res_data),
    .res_idx  (res_idx),
    .res_rdy  (res_rdy),
    .done     (done),
    .err_sync (err_sync)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: result handshakes against the scoreboard, plus hold/halt checks.
  always @(negedge clk) begin
    if (prev_v && !prev_rdy && rst) begin
      check("hold_res_v", res_v, 1);
      check("hold_res_idx", res_idx, prev_idx);
      check("hold_res_data", res_data, prev_data);
    end
    if (res_v) begin
      check("halt_during_drain", halt_out, 1);
      if (res_rdy) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got idx %0d data 0x%0h, required no result", res_idx, res_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("res_idx", res_idx, mon_e.idx);
          check("res_data", res_data, mon_e.data);
        end
      end
    end
    prev_v    = res_v;
    prev_rdy  = res_rdy;
    prev_idx  = res_idx;
    prev_data = res_data;
  end

  function automatic logic [CW-1:0] col_one(input int pos, input logic [DW-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    c[pos*DW +: DW] = v;
    return c;
  endfunction

  function automatic logic [CW-1:0] col_all(input logic [DW-1:0] v);
    logic [CW-1:0] c;
    for (int i = 0; i < N_NODE; i++) c[i*DW +: DW] = v;
    return c;
  endfunction

  task automatic push_exp(input int idx, input logic [DW-1:0] data);
    exp_t e;
    e.idx  = IDX_W'(idx);
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Present a beat and hold it until the DUT is not halted (it is taken at the next edge).
  task automatic send_beat(input logic [CW-1:0] col, input logic [DW-1:0] x);
    int g;
    @(posedge clk); #1;
    mx_v = 1'b1; ft_v = 1'b1; mx_col = col; ft_data = x;
    @(negedge clk);
    g = 0;
    while (halt_out && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_accept_timeout: got halt_out=1, required 0 within 200 cycles");
    end
    t_last = cyc;
  endtask

  task automatic idle_in();
    @(posedge clk); #1;
    mx_v = 1'b0; ft_v = 1'b0;
  endtask

  task automatic wait_sig(input string name, input bit want_done, output int at);
    at = -1;
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      if ((want_done && done) || (!want_done && res_v)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no event, required one within 200 cycles", name);
    end
  endtask

  // Drain with res_rdy cycling 1,0,0,1 until done.
  task automatic drain_pattern();
    logic [3:0] pat;
    bit         seen;
    pat  = 4'b1001;
    seen = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      res_rdy = pat[k % 4];
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    res_rdy = 1'b1;
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_pattern_timeout: got no done, required done within 400 cycles");
    end
  endtask

  initial begin
    int at;
    rst = 1'b0; mx_v = 1'b0; ft_v = 1'b0; mx_col = '0; ft_data = '0; res_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_halt_out", halt_out, 0);
    check("rst_res_v", res_v, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_idx", res_idx, 0);
    check("rst_done", done, 0);
    check("rst_err_sync", err_sync, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Identity A, x_j = j*1.0 -> y_i = i*1.0, with latency checks.
    for (int i = 0; i < N_NODE; i++) push_exp(i, DW'(i * 256));
    for (int j = 0; j < N_NODE; j++) send_beat(col_one(j, 16'h0100), DW'(j * 256));
    idle_in();
    @(negedge clk);
    check("halt_after_last", halt_out, 1);
    wait_sig("first_res_v", 1'b0, at);
    check("first_res_v_cycle", at, t_last + 3);
    wait_sig("done", 1'b1, at);
    check("done_cycle", at, t_last + 28);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("halt_released", halt_out, 0);

    // Positive saturation, drained with a stalling consumer.
    for (int i = 0; i < N_NODE; i++) push_exp(i, 16'h7FFF);
    for (int j = 0; j < N_NODE; j++) send_beat(col_all(16'h7FFF), 16'h7FFF);
    idle_in();
    drain_pattern();

    // Negative saturation (or ReLU to zero).
    for (int i = 0; i < N_NODE; i++) push_exp(i, NEG_EXP);
    for (int j = 0; j < N_NODE; j++) send_beat(col_all(16'h7FFF), 16'h8001);
    idle_in();
    wait_sig("done_neg", 1'b1, at);

    // Misaligned beat at column 3 is dropped; 25 x (1.0 * 1/16) = 25/16 = 0x0190.
    check("err_before_misalign", err_sync, 0);
    for (int i = 0; i < N_NODE; i++) push_exp(i, 16'h0190);
    for (int j = 0; j < N_NODE; j++) begin
      if (j == 3) begin
        @(posedge clk); #1;
        mx_v = 1'b1; ft_v = 1'b0; mx_col = col_all(16'h7FFF); ft_data = 16'h7FFF;
        @(negedge clk);
      end
      send_beat(col_all(16'h0100), 16'h0010);
    end
    idle_in();
    check("err_sync_set", err_sync, 1);
    wait_sig("done_misalign", 1'b1, at);
    check("err_sync_sticky", err_sync, 1);

    // Reset mid-vector, then a clean identity run.
    for (int j = 0; j < 12; j++) send_beat(col_all(16'h7FFF), 16'h7FFF);
    @(posedge clk); #1;
    rst = 1'b0; mx_v = 1'b0; ft_v = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_halt_out", halt_out, 0);
    check("midrst_res_v", res_v, 0);
    check("midrst_err_sync", err_sync, 0);
    check("midrst_done", done, 0);
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < N_NODE; i++) push_exp(i, DW'(i * 256));
    for (int j = 0; j < N_NODE; j++) send_beat(col_one(j, 16'h0100), DW'(j * 256));
    idle_in();
    wait_sig("done_after_rst", 1'b1, at);

    // Back-to-back: anti-diagonal then identity; second vector waits out the halt.
    for (int i = 0; i < N_NODE; i++) push_exp(i, DW'((N_NODE - 1 - i) * 256));
    for (int i = 0; i < N_NODE; i++) push_exp(i, DW'(i * 256));
    for (int j = 0; j < N_NODE; j++) send_beat(col_one(N_NODE - 1 - j, 16'h0100), DW'(j * 256));
    for (int j = 0; j < N_NODE; j++) send_beat(col_one(j, 16'h0100), DW'(j * 256));
    idle_in();
    wait_sig("done_b2b", 1'b1, at);
    check("b2b_err_sync", err_sync, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/gcn_agg_acc.md
Name: gcn_agg_acc

Overview:
- Sits directly downstream of the A-matrix BRAM controller.
- Consumes one 25-element A-matrix column per beat (N_NODE x 16-bit, signed Q8.8) together with one matching feature scalar x_j.
- Accumulates y = A·x as a sequence of outer-product column updates.
- After N_NODE columns, drains the N_NODE results serially to the conv1x1 stage and back-pressures the upstream controller through its halt input.

Parameters:
- N_NODE, 25, nodes per vector; also the number of columns per accumulation.
- DW, 16, element width of A and x (signed).
- ACC_W, 40, accumulator width per node.
- FRAC, 8, fractional bits removed on output (arithmetic right shift).
- IDX_W, 5, width of the result index, ceil(log2(N_NODE)).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- mx_v  in  1  column valid (driven by the A-matrix data_v).
- mx_col  in  N_NODE*DW  A column; element i occupies bits [i*DW +: DW].
- ft_v  in  1  feature scalar valid.
- ft_data  in  DW  feature scalar x_j, signed.
- halt_out  out  1  back-pressure to the A-matrix halt input.
- res_v  out  1  result valid.
- res_data  out  DW  saturated result y_i.
- res_idx  out  IDX_W  node index i of res_data.
- res_rdy  in  1  downstream ready.
- done  out  1  one-cycle pulse after the last result is accepted.
- err_sync  out  1  sticky flag: mx_v and ft_v were misaligned.

Behaviour:
- Reset (rst low at a clk edge):
  - state=IDLE; all accumulators, column counter and pipeline valids cleared.
  - halt_out=0, res_v=0, res_data=0, res_idx=0, done=0, err_sync=0.
  - Reset mid-operation discards all partial sums; no result is emitted.
- Beat accept: a beat is accepted when mx_v && ft_v && !halt_out.
- Misaligned valids:
  - mx_v && !ft_v, or ft_v && !mx_v, while halt_out=0: the beat is dropped and err_sync is set (sticky until reset).
  - A valid arriving while halt_out=1 is ignored and does not set err_sync.
- Pipeline:
  - S1 registers N_NODE signed DW x DW products (2*DW bits each).
  - S2 sign-extends each product to ACC_W and adds it into acc[i].
  - Accept-to-accumulate latency is 2 cycles; throughput is one column per cycle.
- States:
  - IDLE: halt_out=0. The first accepted beat moves to ACC.
  - ACC: col_cnt increments on each accept. On the accept with col_cnt==N_NODE-1, halt_out is asserted from the next cycle and the state moves to FLUSH.
  - FLUSH: halt_out=1; waits until S1 and S2 are empty (2 cycles), then enters DRAIN with res_idx=0.
  - DRAIN: halt_out=1.
    - res_v=1 and res_data=sat(acc[res_idx] >>> FRAC) to signed DW: clamp to +32767 / -32768.
    - On res_v && res_rdy: acc[res_idx] is cleared and res_idx increments.
    - res_v/res_data/res_idx are held stable while res_rdy=0.
    - On acceptance of index N_NODE-1: done=1 for one cycle, res_v=0, col_cnt=0, halt_out drops next cycle, state returns to IDLE.
- Timing: last column accepted at cycle t gives halt_out=1 at t+1 and the first res_v at t+3. With res_rdy held high, the last result is at t+27 and done is at t+28.
- Width rule: the worst-case sum 25*2^30 fits in ACC_W=40 with no wrap. Overflow is handled only by the output saturation.
- Illegal state encodings return to IDLE.

Optional Feature:
- Macro: GCN_AGG_RELU_EN.
- Defined: a negative saturated result is output as 0 (fused ReLU ahead of conv1x1).
- Undefined: the signed saturated result passes through unchanged.
- Accumulation behaviour is identical in both cases.

Decomposition:
- Shared package gcn_pkg:
  - constants N_NODE, DW, ACC_W, FRAC;
  - state enum (IDLE, ACC, FLUSH, DRAIN);
  - saturate/shift function sat_shift(acc) shared with the conv1x1 stage.
- One sub-module, gcn_mac_lane: a single product register plus accumulator with clear. It is instantiated N_NODE times with a generate loop.

Test Plan:
- Identity A (diagonal 0x0100), x_j = j*0x0100 for j=0..24, res_rdy=1 -> res_data for i=0..24 is 0x0000..0x1800 in order; done pulses at t+28.
- All A=0x7FFF, all x=0x7FFF -> every result is saturated to 0x7FFF. With GCN_AGG_RELU_EN and x=0x8001 -> every result is 0x0000.
- During DRAIN, res_rdy toggles 1,0,0,1 -> res_idx/res_data held while low; halt_out stays 1 throughout; no result is lost or duplicated.
- mx_v pulses with ft_v=0 at column 3 -> err_sync=1 and col_cnt unchanged; a realigned beat continues accumulation correctly.
- rst driven low at column 12, then a clean 25-column run -> results match a fresh run with no residue from the aborted vector.
- Two back-to-back vectors -> the second vector's results are independent (accumulators cleared during drain); upstream beats presented while halt_out=1 are not consumed.
